// File: rtl/fetch_queue_if.sv
// Lane type shared by fetch, the queue and decode, plus the queue's bus interface.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_valid;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
  } decode_require_t;

endpackage

// Fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int DEPTH = 16
);
  import fetch_queue_pkg::*;

  logic                          flush;
  decode_require_t [3:0]         fetch_group;
  logic                          fetch_group_valid;
  logic                          fetch_ready;
  decode_require_t [3:0]         decode_entries;
  logic                          decode_accept;
  logic [$clog2(DEPTH+1)-1:0]    count;

  // Environment side: drives fetch lanes and decode acceptance.
  modport master (
    output flush, fetch_group, fetch_group_valid, decode_accept,
    input  fetch_ready, decode_entries, count
  );

  // Queue side.
  modport slave (
    input  flush, fetch_group, fetch_group_valid, decode_accept,
    output fetch_ready, decode_entries, count
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between the 4-wide fetch stage and decode: compacts the
// valid lanes of each fetch group into a circular buffer and presents the
// oldest four entries to decode. Flush and reset drop everything.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = $clog2(IN_WIDTH + 1);

  decode_require_t                  mem [DEPTH];
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic [CNT_W-1:0]                 count_q;
  logic [CNT_W-1:0]                 count_next;
  logic                             ready;
  logic                             enq;
  logic                             deq;
  logic [LANE_W-1:0]                n_in;
  logic [LANE_W-1:0]                n_out;
  logic [LANE_W-1:0]                slot [IN_WIDTH];
  decode_require_t [OUT_WIDTH-1:0]  entries;

  // Ready looks only at the registered count, so decode_accept never reaches fetch_ready.
  assign ready = count_q <= CNT_W'(DEPTH - IN_WIDTH);
  assign enq   = bus.fetch_group_valid && ready && !bus.flush;
  assign deq   = bus.decode_accept && !bus.flush;
  assign n_out = (count_q >= CNT_W'(OUT_WIDTH)) ? LANE_W'(OUT_WIDTH) : LANE_W'(count_q);

  // Compaction: each lane's write offset from tail is the number of valid lanes below it.
  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      slot[i] = n_in;
      if (bus.fetch_group[i].is_valid) n_in = n_in + LANE_W'(1);
    end
  end

  // Occupancy after this cycle's enqueue and dequeue.
  always_comb begin
    count_next = count_q;
    if (enq) count_next = count_next + CNT_W'(n_in);
    if (deq) count_next = count_next - CNT_W'(n_out);
  end

  // Write valid lanes in program order at tail, tail+1, ...
  // NOTE: the array has no reset; output is_valid comes from count, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (bus.fetch_group[i].is_valid) mem[tail + PTR_W'(slot[i])] <= bus.fetch_group[i];
      end
    end
  end

  // Pointers and occupancy; reset and flush both return the queue to empty.
  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(n_in);
      if (deq) head <= head + PTR_W'(n_out);
      count_q <= count_next;
    end
  end

  // Oldest entries to decode; lanes at or beyond count are marked invalid.
  always_comb begin
    for (int i = 0; i < OUT_WIDTH; i++) begin
      entries[i]          = mem[head + PTR_W'(i)];
      entries[i].is_valid = count_q > CNT_W'(i);
    end
  end

  assign bus.decode_entries = entries;
  assign bus.fetch_ready    = ready;
  assign bus.count          = count_q;

  // Occupancy invariants.
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
  a_ptr_diff:    assert property (@(posedge clk) disable iff (rst) (tail - head) == count_q[PTR_W-1:0]);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes accepted lanes into a
// scoreboard queue; a negedge monitor compares decode lanes against it.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  decode_require_t exp_q [$];

  fetch_queue_if #(.DEPTH(16)) bus ();

  fetch_queue #(.DEPTH(16), .IN_WIDTH(4), .OUT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic decode_require_t mk_lane(input logic [31:0] p, input logic v);
    decode_require_t l;
    l.pc                   = p;
    l.inst                 = ~p;
    l.is_valid             = v;
    l.predict_pc_addr      = p + 32'h8;
    l.predict_brunch_taken = p[2];
    return l;
  endfunction

  function automatic logic [3:0] valid_bits();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = bus.decode_entries[i].is_valid;
    return b;
  endfunction

  // One clock: drive inputs, wait for the edge, update the scoreboard, return at edge+1.
  task automatic cycle(input logic [3:0] mask, input logic [31:0] base, input logic gv,
                       input logic acc, input logic fl, input logic r, input logic exp_enq);
    for (int i = 0; i < 4; i++) bus.fetch_group[i] = mk_lane(base + 32'(4 * i), mask[i]);
    bus.fetch_group_valid = gv;
    bus.decode_accept     = acc;
    bus.flush             = fl;
    rst                   = r;
    @(posedge clk);
    if (fl || r) exp_q.delete();
    else if (exp_enq) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) exp_q.push_back(mk_lane(base + 32'(4 * i), 1'b1));
    end
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: lanes shown to decode must match the oldest scoreboard entries.
  always @(negedge clk) begin
    int n_exp;
    if (!rst) begin
      n_exp = (exp_q.size() > 4) ? 4 : exp_q.size();
      check("mon_valid", 128'(valid_bits()), 128'((4'b1 << n_exp) - 4'b1));
      check("mon_count", 128'(bus.count), 128'(exp_q.size()));
      for (int i = 0; i < n_exp; i++)
        check($sformatf("mon_lane%0d", i), 128'(bus.decode_entries[i]), 128'(exp_q[i]));
      if (bus.decode_accept && !bus.flush)
        for (int i = 0; i < n_exp; i++) void'(exp_q.pop_front());
    end
  end

  initial begin
    bus.fetch_group       = '0;
    bus.fetch_group_valid = 1'b0;
    bus.decode_accept     = 1'b0;
    bus.flush             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_count", 128'(bus.count), 128'(0));
    check("rst_ready", 128'(bus.fetch_ready), 128'(1));
    check("rst_valid", 128'(valid_bits()), 128'(4'b0000));

    // 1: full group, then one accept
    cycle(4'hF, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_count", 128'(bus.count), 128'(4));
    check("t1_valid", 128'(valid_bits()), 128'(4'b1111));
    check("t1_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h1000));
    check("t1_pc3", 128'(bus.decode_entries[3].pc), 128'(32'h100C));
    drain(1);
    check("t1_drain_count", 128'(bus.count), 128'(0));
    check("t1_drain_valid", 128'(valid_bits()), 128'(4'b0000));

    // 2: sparse group, lanes 0 and 2 valid
    cycle(4'b0101, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_count", 128'(bus.count), 128'(2));
    check("t2_valid", 128'(valid_bits()), 128'(4'b0011));
    check("t2_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h2000));
    check("t2_pc1", 128'(bus.decode_entries[1].pc), 128'(32'h2008));
    drain(1);

    // 3: fill to full, fifth group ignored, one accept reopens
    for (int g = 0; g < 4; g++)
      cycle(4'hF, 32'h4000 + 32'(16 * g), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_full_count", 128'(bus.count), 128'(16));
    check("t3_full_ready", 128'(bus.fetch_ready), 128'(0));
    cycle(4'hF, 32'h4040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ignored_count", 128'(bus.count), 128'(16));
    drain(1);
    check("t3_accept_count", 128'(bus.count), 128'(12));
    check("t3_accept_ready", 128'(bus.fetch_ready), 128'(1));
    drain(3);
    check("t3_empty", 128'(bus.count), 128'(0));

    // 4: steady 4 in / 4 out across the pointer wrap
    for (int k = 0; k < 10; k++) begin
      cycle(4'hF, 32'h5000 + 32'(16 * k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t4_count", 128'(bus.count), 128'(4));
    end
    check("t4_last_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h5090));
    drain(1);

    // 5: flush together with a group and an accept at count=8
    cycle(4'hF, 32'h6000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(4'hF, 32'h6010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_pre_count", 128'(bus.count), 128'(8));
    cycle(4'hF, 32'h6020, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_flush_count", 128'(bus.count), 128'(0));
    check("t5_flush_valid", 128'(valid_bits()), 128'(4'b0000));
    check("t5_flush_ready", 128'(bus.fetch_ready), 128'(1));
    cycle(4'b0001, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_after_valid", 128'(valid_bits()), 128'(4'b0001));
    check("t5_after_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h3000));
    drain(1);

    // 6: reset with count=6 straddling the wrap (head=14, tail=4)
    for (int g = 0; g < 3; g++)
      cycle(4'hF, 32'h6100 + 32'(16 * g), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0001, 32'h6200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(4);
    cycle(4'hF, 32'h7000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0011, 32'h7010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_pre_count", 128'(bus.count), 128'(6));
    check("t6_pre_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h7000));
    cycle(4'hF, 32'h7100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t6_rst_count", 128'(bus.count), 128'(0));
    check("t6_rst_valid", 128'(valid_bits()), 128'(4'b0000));
    check("t6_rst_ready", 128'(bus.fetch_ready), 128'(1));
    cycle(4'hF, 32'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_resume_count", 128'(bus.count), 128'(4));
    check("t6_resume_pc0", 128'(bus.decode_entries[0].pc), 128'(32'h8000));
    check("t6_resume_pc2", 128'(bus.decode_entries[2].pc), 128'(32'h8008));
    drain(2);
    cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
